// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial ALU controller built around one shared 1-bit ALU slice.
// Processes one operand bit per clock, LSB first: add (A+B), subtract (B-A),
// unsigned compare and bitwise AND. Results are registered and held until the
// next accepted start.
// Optional feature: define ALU_SERIAL_CTRL_OVF_EN to produce the signed overflow
// flag on ovf; when the macro is undefined ovf is tied to 0 and adds no state.

// One bit of the team ALU.
// Mode {m1,m0}: 00 a+b, 01 b-a (as b + ~a + cin), 10 compare, 11 a&b.
module ALU_1_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic m1,
   input  logic m0,
   output logic f,
   output logic cout,
   output logic a_gt_b,
   output logic a_lt_b
);
   logic x;

   // Subtraction inverts A so the same full adder computes b + ~a + cin.
   assign x = m0 ? ~a : a;

   // Mode-selected bit result and carry; non-arithmetic modes never carry.
   always_comb begin
      f    = 1'b0;
      cout = 1'b0;
      case ({m1, m0})
         2'b00, 2'b01: begin
            f    = x ^ b ^ cin;
            cout = (x & b) | (x & cin) | (b & cin);
         end
         2'b11:   f = a & b;
         default: f = 1'b0;
      endcase
   end

   assign a_gt_b = a & ~b;
   assign a_lt_b = ~a & b;
endmodule

module alu_serial_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             eq,
   output logic             gt,
   output logic             lt,
   output logic             ovf
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_reg;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [1:0]       op_reg;
   logic             carry_reg;
   logic             gt_acc_reg;
   logic             lt_acc_reg;
   logic             busy_reg;
   logic             done_reg;
   logic [WIDTH-1:0] result_reg;
   logic             cout_reg;
   logic             eq_reg;
   logic             gt_reg;
   logic             lt_reg;

   logic slice_a;
   logic slice_b;
   logic slice_f;
   logic slice_cout;
   logic slice_gt;
   logic slice_lt;
   logic is_arith;
   logic is_cmp;
   logic last_bit;
   logic gt_fin;
   logic lt_fin;

   assign slice_a  = a_reg[cnt_reg];
   assign slice_b  = b_reg[cnt_reg];
   assign is_arith = ~op_reg[1];
   assign is_cmp   = (op_reg == 2'b10);
   assign last_bit = (cnt_reg == LAST_BIT);

   ALU_1_bit u_slice (
      .a      (slice_a),
      .b      (slice_b),
      .cin    (carry_reg),
      .m1     (op_reg[1]),
      .m0     (op_reg[0]),
      .f      (slice_f),
      .cout   (slice_cout),
      .a_gt_b (slice_gt),
      .a_lt_b (slice_lt)
   );

   // Compare accumulators after folding in the current bit; a higher differing
   // bit always overrides whatever the lower bits decided.
   always_comb begin
      gt_fin = gt_acc_reg;
      lt_fin = lt_acc_reg;
      if (slice_gt) begin
         gt_fin = 1'b1;
         lt_fin = 1'b0;
      end else if (slice_lt) begin
         gt_fin = 1'b0;
         lt_fin = 1'b1;
      end
   end

`ifdef ALU_SERIAL_CTRL_OVF_EN
   logic ovf_reg;
   assign ovf = ovf_reg;
`else
   assign ovf = 1'b0;
`endif

   // Control FSM plus datapath: capture on start, one bit per RUN cycle, pulse done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= S_IDLE;
         cnt_reg    <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         op_reg     <= 2'b00;
         carry_reg  <= 1'b0;
         gt_acc_reg <= 1'b0;
         lt_acc_reg <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         result_reg <= '0;
         cout_reg   <= 1'b0;
         eq_reg     <= 1'b0;
         gt_reg     <= 1'b0;
         lt_reg     <= 1'b0;
`ifdef ALU_SERIAL_CTRL_OVF_EN
         ovf_reg    <= 1'b0;
`endif
      end else begin
         case (state_reg)
            S_IDLE, S_DONE: begin
               done_reg <= 1'b0;
               if (start) begin
                  state_reg  <= S_RUN;
                  busy_reg   <= 1'b1;
                  cnt_reg    <= '0;
                  a_reg      <= a;
                  b_reg      <= b;
                  op_reg     <= op;
                  // Subtraction is b + ~a + 1, so the carry chain starts at 1.
                  carry_reg  <= (op == 2'b01);
                  gt_acc_reg <= 1'b0;
                  lt_acc_reg <= 1'b0;
                  result_reg <= '0;
                  cout_reg   <= 1'b0;
                  eq_reg     <= 1'b0;
                  gt_reg     <= 1'b0;
                  lt_reg     <= 1'b0;
`ifdef ALU_SERIAL_CTRL_OVF_EN
                  ovf_reg    <= 1'b0;
`endif
               end else begin
                  state_reg <= S_IDLE;
               end
            end

            S_RUN: begin
               result_reg[cnt_reg] <= slice_f;
               carry_reg           <= slice_cout;
               gt_acc_reg          <= gt_fin;
               lt_acc_reg          <= lt_fin;
               if (last_bit) begin
                  state_reg <= S_DONE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  cnt_reg   <= '0;
                  cout_reg  <= is_arith & slice_cout;
                  eq_reg    <= is_cmp & ~gt_fin & ~lt_fin;
                  gt_reg    <= is_cmp & gt_fin;
                  lt_reg    <= is_cmp & lt_fin;
`ifdef ALU_SERIAL_CTRL_OVF_EN
                  // carry_reg is the carry into the MSB stage on this cycle.
                  ovf_reg   <= is_arith & (carry_reg ^ slice_cout);
`endif
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end

            default: begin
               state_reg <= S_IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = busy_reg;
   assign done   = done_reg;
   assign result = result_reg;
   assign cout   = cout_reg;
   assign eq     = eq_reg;
   assign gt     = gt_reg;
   assign lt     = lt_reg;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl (WIDTH=4): stimulus pushes the expected
// response of each accepted operation, a negedge monitor pops it on done.
module tb_alu_serial_ctrl;
   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             eq;
   logic             gt;
   logic             lt;
   logic             ovf;

   typedef struct {
      logic [1:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] res;
      logic             cout;
      logic             eq;
      logic             gt;
      logic             lt;
      logic             ovf;
   } vec_t;

   typedef struct {
      vec_t v;
      int   due;
   } exp_t;

   vec_t vecs[11];
   exp_t q[$];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   bit   hold_valid = 1'b0;
   vec_t last_v;

   alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .eq     (eq),
      .gt     (gt),
      .lt     (lt),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] o, input logic [3:0] va, input logic [3:0] vb,
                               input logic [3:0] r, input logic c, input logic e,
                               input logic g, input logic l, input logic v);
      vec_t t;
      t.op = o; t.a = va; t.b = vb; t.res = r; t.cout = c;
      t.eq = e; t.gt = g; t.lt = l;
`ifdef ALU_SERIAL_CTRL_OVF_EN
      t.ovf = v;
`else
      t.ovf = 1'b0 & v;
`endif
      return t;
   endfunction

   function automatic logic [31:0] pack_out(input vec_t t);
      return {23'd0, t.res, t.cout, t.eq, t.gt, t.lt, t.ovf};
   endfunction

   // Monitor: check each done against the scoreboard, and held outputs while idle.
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_valid = 1'b0;
      end else if (done) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("done_cycle", cyc, e.due);
            chk("result", {28'd0, result}, {28'd0, e.v.res});
            chk("cout", {31'd0, cout}, {31'd0, e.v.cout});
            chk("flags_eq_gt_lt", {29'd0, eq, gt, lt}, {29'd0, e.v.eq, e.v.gt, e.v.lt});
            chk("ovf", {31'd0, ovf}, {31'd0, e.v.ovf});
            chk("busy_in_done", {31'd0, busy}, 32'd0);
            last_v = e.v;
            hold_valid = 1'b1;
         end
      end else begin
         if (q.size() > 0 && cyc > q[0].due) begin
            chk("done_missing", cyc, q[0].due);
            void'(q.pop_front());
         end
         if (busy) hold_valid = 1'b0;
         else if (hold_valid)
            chk("hold", {23'd0, result, cout, eq, gt, lt, ovf}, pack_out(last_v));
      end
   end

   // Present a vector and wait until it is accepted; optionally keep start high.
   task automatic issue(input int idx, input bit keep);
      int   guard;
      exp_t e;
      guard = 0;
      @(negedge clk);
      op = vecs[idx].op; a = vecs[idx].a; b = vecs[idx].b; start = 1'b1;
      while (busy && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 40) chk("accept_timeout", guard, 32'd0);
      @(posedge clk);
      #1;
      e.v = vecs[idx];
      e.due = cyc + WIDTH;
      q.push_back(e);
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
      // Operands wiggle during RUN and must not matter.
      a = ~a; b = ~b; op = op ^ 2'b01;
      if (!keep) start = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (q.size() > 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (q.size() > 0) chk("drain_timeout", q.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      vecs[0]  = mk(2'b00, 4'b0111, 4'b0001, 4'b1000, 0, 0, 0, 0, 1);
      vecs[1]  = mk(2'b01, 4'b0101, 4'b0011, 4'b1110, 0, 0, 0, 0, 0);
      vecs[2]  = mk(2'b01, 4'b0011, 4'b0101, 4'b0010, 1, 0, 0, 0, 0);
      vecs[3]  = mk(2'b10, 4'b1001, 4'b0110, 4'b0000, 0, 0, 1, 0, 0);
      vecs[4]  = mk(2'b10, 4'b0110, 4'b0110, 4'b0000, 0, 1, 0, 0, 0);
      vecs[5]  = mk(2'b10, 4'b0001, 4'b1000, 4'b0000, 0, 0, 0, 1, 0);
      vecs[6]  = mk(2'b11, 4'b1100, 4'b1010, 4'b1000, 0, 0, 0, 0, 0);
      vecs[7]  = mk(2'b00, 4'b1111, 4'b0001, 4'b0000, 1, 0, 0, 0, 0);
      vecs[8]  = mk(2'b10, 4'b1000, 4'b0111, 4'b0000, 0, 0, 1, 0, 0);
      vecs[9]  = mk(2'b01, 4'b0001, 4'b1000, 4'b0111, 1, 0, 0, 0, 1);
      vecs[10] = mk(2'b00, 4'b0101, 4'b0110, 4'b1011, 0, 0, 0, 0, 1);

      rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {22'd0, busy, done, result, cout, eq, gt, lt, ovf}, 32'd0);

      // First start must be taken on the first edge after reset release.
      op = vecs[0].op; a = vecs[0].a; b = vecs[0].b; start = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      e.v = vecs[0];
      e.due = cyc + WIDTH;
      q.push_back(e);
      chk("first_accept_busy", {31'd0, busy}, 32'd1);
      start = 1'b0;
      drain();

      // Single operations with idle gaps.
      for (int i = 1; i <= 5; i++) begin
         issue(i, 1'b0);
         drain();
      end

      // AND with start pulsed mid-RUN: exactly one done expected.
      issue(6, 1'b0);
      @(negedge clk);
      start = 1'b1; a = 4'b1111; b = 4'b1111; op = 2'b00;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (8) @(negedge clk);

      // Back-to-back with start held high the whole time.
      for (int i = 7; i <= 10; i++) issue(i, i != 10);
      issue(1, 1'b0);
      drain();
      repeat (3) @(negedge clk);

      // Reset two cycles into an add: outputs clear at once, no done follows.
      issue(0, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrun_reset_outputs", {22'd0, busy, done, result, cout, eq, gt, lt, ovf}, 32'd0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      issue(10, 1'b0);
      drain();
      issue(0, 1'b0);
      drain();
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
